sprite_draw_datapath: RTL and testbench

- Execution end of the movement command interface: decodes the 4-bit STATE code from the movement FSM, applies position moves to the selected object, and rasterises clear/draw passes to the VGA adapter one pixel per clock.
- Returns doneDrawing as the completion handshake the FSM waits on in its CLEAR and DRAW states.
- PorB selects the object: 0 = player crosshair, 1 = bird.

---
 rtl/sprite_draw_datapath_if.sv | 23 ++
 rtl/sprite_draw_datapath.sv | 179 +++++++++++++++++
 tb/tb_sprite_draw_datapath.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_draw_datapath_if.sv
// Command/pixel bundle between the movement FSM, this datapath and the VGA adapter.
// The FSM side is the master; the datapath is the slave.
interface sprite_draw_datapath_if;
    logic [3:0] STATE;
    logic       PorB;
    logic       doneDrawing;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] obj_x;
    logic [6:0] obj_y;

    modport master (
        output STATE, PorB,
        input  doneDrawing, x, y, colour, plot, obj_x, obj_y
    );

    modport slave (
        input  STATE, PorB,
        output doneDrawing, x, y, colour, plot, obj_x, obj_y
    );
endinterface

// File: rtl/sprite_draw_datapath.sv
// Executes movement-FSM commands: saturating position moves and one-pixel-per-clock
// clear/draw rasters of the selected sprite, with a key-matched done handshake.
module sprite_draw_datapath #(
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter int         SPRITE_W  = 8,
    parameter int         SPRITE_H  = 8,
    parameter int         STEP      = 4,
    parameter int         P_INIT_X  = 76,
    parameter int         P_INIT_Y  = 56,
    parameter int         B_INIT_X  = 0,
    parameter int         B_INIT_Y  = 100,
    parameter logic [2:0] P_COLOUR  = 3'b111,
    parameter logic [2:0] B_COLOUR  = 3'b100,
    parameter logic [2:0] BG_COLOUR = 3'b011
) (
    input logic                   clk,
    input logic                   reset,
    sprite_draw_datapath_if.slave bus
);

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int R_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    localparam logic [3:0] CMD_CLEAR = 4'b0001;
    localparam logic [3:0] CMD_RIGHT = 4'b0010;
    localparam logic [3:0] CMD_LEFT  = 4'b0011;
    localparam logic [3:0] CMD_DRAW  = 4'b0101;
    localparam logic [3:0] CMD_DOWN  = 4'b0110;
    localparam logic [3:0] CMD_UP    = 4'b0111;
    // STATE 1111 is never issued, so this key can never match a real command
    localparam logic [4:0] KEY_NONE  = {4'b1111, 1'b0};

    localparam logic signed [X_W:0] X_MAX_S = (X_W+1)'(SCREEN_W - SPRITE_W);
    localparam logic signed [Y_W:0] Y_MAX_S = (Y_W+1)'(SCREEN_H - SPRITE_H);
    localparam logic signed [X_W:0] STEP_X  = (X_W+1)'(STEP);
    localparam logic signed [Y_W:0] STEP_Y  = (Y_W+1)'(STEP);
    localparam logic [C_W-1:0]      C_LAST  = C_W'(SPRITE_W - 1);
    localparam logic [R_W-1:0]      R_LAST  = R_W'(SPRITE_H - 1);
    localparam logic [C_W-1:0]      C_MID   = C_W'(SPRITE_W / 2);
    localparam logic [R_W-1:0]      R_MID   = R_W'(SPRITE_H / 2);

    typedef enum logic [1:0] {IDLE, RASTER, DONE} state_t;

    function automatic logic [X_W-1:0] clamp_x(input logic signed [X_W:0] v);
        if (v < 0)       return '0;
        if (v > X_MAX_S) return X_MAX_S[X_W-1:0];
        return v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic signed [Y_W:0] v);
        if (v < 0)       return '0;
        if (v > Y_MAX_S) return Y_MAX_S[Y_W-1:0];
        return v[Y_W-1:0];
    endfunction

    state_t              state, state_n;
    logic [4:0]          key, last_key;
    logic                key_new, is_move, is_raster_cmd, last_px, do_move, do_start;
    logic [X_W-1:0]      p_x, b_x, sel_x, ras_x, mv_x;
    logic [Y_W-1:0]      p_y, b_y, sel_y, ras_y, mv_y;
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic [C_W-1:0]      col;
    logic [R_W-1:0]      row;
    logic                ras_bird, ras_clear, done_r;

    assign key     = {bus.STATE, bus.PorB};
    assign key_new = (key != last_key);
    assign sel_x   = bus.PorB ? b_x : p_x;
    assign sel_y   = bus.PorB ? b_y : p_y;
    assign ras_x   = ras_bird ? b_x : p_x;
    assign ras_y   = ras_bird ? b_y : p_y;
    assign last_px = (col == C_LAST) && (row == R_LAST);
    assign mv_x    = clamp_x($signed({1'b0, sel_x}) + dx);
    assign mv_y    = clamp_y($signed({1'b0, sel_y}) + dy);

    always_comb begin
        dx            = '0;
        dy            = '0;
        is_move       = 1'b0;
        is_raster_cmd = 1'b0;
        case (bus.STATE)
            CMD_RIGHT: begin dx = STEP_X;  is_move = 1'b1; end
            CMD_LEFT:  begin dx = -STEP_X; is_move = 1'b1; end
            CMD_DOWN:  begin dy = STEP_Y;  is_move = 1'b1; end
            CMD_UP:    begin dy = -STEP_Y; is_move = 1'b1; end
            CMD_CLEAR, CMD_DRAW: is_raster_cmd = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        do_move  = 1'b0;
        do_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_new) begin
                    do_move = is_move;
                    if (is_raster_cmd) begin
                        do_start = 1'b1;
                        state_n  = RASTER;
                    end
                end
            end
            RASTER:  if (last_px) state_n = DONE;
            DONE:    if (key_new) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_key  <= KEY_NONE;
            done_r    <= 1'b0;
            col       <= '0;
            row       <= '0;
            ras_bird  <= 1'b0;
            ras_clear <= 1'b0;
            p_x       <= X_W'(P_INIT_X);
            p_y       <= Y_W'(P_INIT_Y);
            b_x       <= X_W'(B_INIT_X);
            b_y       <= Y_W'(B_INIT_Y);
        end else begin
            if (state == IDLE && key_new) last_key <= key;
            if (do_move) begin
                if (bus.PorB) begin
                    b_x <= mv_x;
                    b_y <= mv_y;
                end else begin
                    p_x <= mv_x;
                    p_y <= mv_y;
                end
            end
            if (do_start) begin
                col       <= '0;
                row       <= '0;
                ras_bird  <= bus.PorB;
                ras_clear <= (bus.STATE == CMD_CLEAR);
            end else if (state == RASTER) begin
                if (col == C_LAST) begin
                    col <= '0;
                    row <= row + R_W'(1);
                end else begin
                    col <= col + C_W'(1);
                end
            end
            if (state == RASTER && last_px)  done_r <= 1'b1;
            else if (state == DONE && key_new) done_r <= 1'b0;
        end
    end

    // Pixel outputs follow the raster state directly so a reset blanks plot at once
    always_comb begin
        bus.x      = '0;
        bus.y      = '0;
        bus.colour = '0;
        bus.plot   = 1'b0;
        if (state == RASTER) begin
            bus.x      = ras_x + X_W'(col);
            bus.y      = ras_y + Y_W'(row);
            bus.plot   = ras_clear || ras_bird || (col == C_MID) || (row == R_MID);
            bus.colour = ras_clear ? BG_COLOUR : (ras_bird ? B_COLOUR : P_COLOUR);
        end
    end

    assign bus.obj_x       = sel_x;
    assign bus.obj_y       = sel_y;
    assign bus.doneDrawing = done_r && !key_new;

endmodule

// File: tb/tb_sprite_draw_datapath.sv
// Scoreboard bench: expected pixels are queued when a raster command is driven and
// compared against every plotted pixel; positions are tracked by a small model.
module tb_sprite_draw_datapath;

    localparam logic [3:0] NOOP  = 4'b0000;
    localparam logic [3:0] CLEAR = 4'b0001;
    localparam logic [3:0] RIGHT = 4'b0010;
    localparam logic [3:0] LEFT  = 4'b0011;
    localparam logic [3:0] DRAW  = 4'b0101;
    localparam logic [3:0] DOWN  = 4'b0110;
    localparam logic [3:0] UP    = 4'b0111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_draw_datapath_if bus();
    sprite_draw_datapath dut (.clk(clk), .reset(reset), .bus(bus));

    int          n_checks = 0;
    int          n_pass   = 0;
    int          plot_cnt = 0;
    logic [31:0] exp_q[$];
    int          px = 76, py = 56, bx = 0, by = 100;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] pix(input int xv, input int yv, input logic [2:0] c);
        logic [7:0] x8;
        logic [6:0] y7;
        x8 = xv[7:0];
        y7 = yv[6:0];
        return {14'd0, x8, y7, c};
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic push_raster(input bit clr, input bit bird);
        int ox, oy;
        logic [2:0] c;
        ox = bird ? bx : px;
        oy = bird ? by : py;
        c  = clr ? 3'b011 : (bird ? 3'b100 : 3'b111);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++)
                if (clr || bird || k == 4 || r == 4) exp_q.push_back(pix(ox + k, oy + r, c));
    endtask

    task automatic apply_move(input logic [3:0] cmd, input bit sel);
        int dx, dy;
        dx = (cmd == RIGHT) ? 4 : (cmd == LEFT) ? -4 : 0;
        dy = (cmd == DOWN)  ? 4 : (cmd == UP)   ? -4 : 0;
        if (sel) begin bx = clampi(bx + dx, 152); by = clampi(by + dy, 112); end
        else     begin px = clampi(px + dx, 152); py = clampi(py + dy, 112); end
    endtask

    // Held two edges: the first may only take the datapath from DONE back to IDLE
    task automatic drive_move(input logic [3:0] cmd, input bit sel);
        @(posedge clk); #1;
        bus.STATE = cmd;
        bus.PorB  = sel;
        repeat (2) @(posedge clk);
        #1 bus.STATE = NOOP;
        apply_move(cmd, sel);
    endtask

    task automatic start_raster(input logic [3:0] cmd, input bit sel);
        @(posedge clk); #1;
        bus.STATE = cmd;
        bus.PorB  = sel;
        plot_cnt  = 0;
        push_raster(cmd == CLEAR, sel);
    endtask

    task automatic wait_done(input string tag);
        @(negedge clk);
        for (int i = 0; i < 200 && bus.doneDrawing !== 1'b1; i++) @(negedge clk);
        check_val(tag, 32'(bus.doneDrawing), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.plot) begin
            plot_cnt++;
            if (exp_q.size() == 0) check_val("pix_extra", 32'(exp_q.size()), 32'd1);
            else check_val("pix", {14'd0, bus.x, bus.y, bus.colour}, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        bus.STATE = NOOP;
        bus.PorB  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_plot",   32'(bus.plot), 32'd0);
        check_val("rst_x",      32'(bus.x), 32'd0);
        check_val("rst_colour", 32'(bus.colour), 32'd0);
        check_val("rst_done",   32'(bus.doneDrawing), 32'd0);
        check_val("rst_px",     32'(bus.obj_x), 32'd76);
        check_val("rst_py",     32'(bus.obj_y), 32'd56);
        bus.PorB = 1'b1;
        #1;
        check_val("rst_bx", 32'(bus.obj_x), 32'd0);
        check_val("rst_by", 32'(bus.obj_y), 32'd100);
        bus.PorB = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // Clear the player box; first pixel the cycle after sampling
        start_raster(CLEAR, 1'b0);
        @(negedge clk);
        check_val("t1_pre_plot", 32'(bus.plot), 32'd0);
        @(negedge clk);
        check_val("t1_first_plot", 32'(bus.plot), 32'd1);
        check_val("t1_first_x",    32'(bus.x), 32'd76);
        check_val("t1_first_y",    32'(bus.y), 32'd56);
        check_val("t1_busy_done",  32'(bus.doneDrawing), 32'd0);
        wait_done("t1_done");
        check_val("t1_count", 32'(plot_cnt), 32'd64);
        repeat (5) @(negedge clk);
        check_val("t1_done_hold", 32'(bus.doneDrawing), 32'd1);

        // Move player then draw the crosshair
        drive_move(RIGHT, 1'b0);
        drive_move(DOWN, 1'b0);
        @(negedge clk);
        check_val("t2_px", 32'(bus.obj_x), 32'd80);
        check_val("t2_py", 32'(bus.obj_y), 32'd60);
        start_raster(DRAW, 1'b0);
        #1 check_val("t2_done_low", 32'(bus.doneDrawing), 32'd0);
        wait_done("t2_done");
        check_val("t2_count", 32'(plot_cnt), 32'd15);
        check_val("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Bird saturation at both edges
        drive_move(LEFT, 1'b1);
        @(negedge clk);
        check_val("t3_bx_clamp", 32'(bus.obj_x), 32'(bx));
        drive_move(UP, 1'b1);
        @(negedge clk);
        check_val("t3_by_up", 32'(bus.obj_y), 32'd96);
        for (int k = 0; k < 5; k++) begin
            drive_move(DOWN, 1'b1);
            @(negedge clk);
            check_val("t3_by_down", 32'(bus.obj_y), 32'(by));
        end
        check_val("t3_by_max", 32'(bus.obj_y), 32'd112);

        // A held DRAW rasterises once
        start_raster(DRAW, 1'b1);
        repeat (200) @(negedge clk);
        check_val("t4_count", 32'(plot_cnt), 32'd64);
        check_val("t4_done",  32'(bus.doneDrawing), 32'd1);

        // Code change drops done at once; a move during the raster is ignored
        start_raster(CLEAR, 1'b1);
        #1 check_val("t5_done_drop", 32'(bus.doneDrawing), 32'd0);
        for (int i = 0; i < 100 && plot_cnt < 10; i++) @(posedge clk);
        #1 bus.STATE = RIGHT;
        repeat (3) @(posedge clk);
        #1 bus.STATE = CLEAR;
        wait_done("t5_done");
        check_val("t5_count", 32'(plot_cnt), 32'd64);
        check_val("t5_bx",    32'(bus.obj_x), 32'(bx));
        check_val("t5_by",    32'(bus.obj_y), 32'(by));

        // Player right-edge saturation
        for (int k = 0; k < 20; k++) drive_move(RIGHT, 1'b0);
        @(negedge clk);
        check_val("t6_px_max", 32'(bus.obj_x), 32'd152);

        // Reset in the middle of a raster
        start_raster(DRAW, 1'b1);
        for (int i = 0; i < 100 && plot_cnt < 30; i++) @(posedge clk);
        check_val("t7_reach", 32'(plot_cnt >= 30), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("t7_plot", 32'(bus.plot), 32'd0);
        check_val("t7_done", 32'(bus.doneDrawing), 32'd0);
        check_val("t7_bx",   32'(bus.obj_x), 32'd0);
        check_val("t7_by",   32'(bus.obj_y), 32'd100);
        bus.PorB  = 1'b0;
        bus.STATE = NOOP;
        #1;
        check_val("t7_px", 32'(bus.obj_x), 32'd76);
        check_val("t7_py", 32'(bus.obj_y), 32'd56);
        exp_q.delete();
        px = 76; py = 56; bx = 0; by = 100;
        @(posedge clk); #1 reset = 1'b0;
        start_raster(DRAW, 1'b0);
        wait_done("t7_redraw_done");
        check_val("t7_redraw_count", 32'(plot_cnt), 32'd15);
        check_val("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
